// File: rtl/register_reader_pkg.sv
// Shared types and default geometry for the latch register bank
// and its serial read-side companion.
package register_reader_pkg;

    localparam int RR_WIDTH = 8;
    localparam int RR_DEPTH = 8;
    localparam int RR_AW    = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/register_reader_piso_shifter.sv
// Parallel-in serial-out shift register, LSB first, zero fill.
// Load has priority over shift.
module piso_shifter
    import register_reader_pkg::*;
#(
    parameter int WIDTH = RR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = din;
        end else if (shift_en) begin
            data_d = {1'b0, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign sout = data_q[0];

endmodule

// File: rtl/register_reader.sv
// Reads one register of the latch bank and streams it LSB-first
// over a valid/ready bit stream, then presents it in parallel.
module register_reader
    import register_reader_pkg::*;
#(
    parameter int WIDTH = RR_WIDTH,
    parameter int DEPTH = RR_DEPTH,
    parameter int AW    = RR_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH*DEPTH-1:0] bank,
    input  logic [AW-1:0]      addr,
    input  logic               start,
    output logic               busy,
    output logic               sout,
    output logic               sout_valid,
    input  logic               sout_ready,
    output logic [WIDTH-1:0]   dout,
    output logic               done,
    output logic               err
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             err_pend_q, err_pend_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] snap;
    logic             in_range;
    logic             load;
    logic             shift_en;

    // Decode by comparison so an out-of-range index never slices past bank.
    always_comb begin
        sel_word = '0;
        in_range = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_q == AW'(i)) begin
                sel_word = bank[i*WIDTH +: WIDTH];
                in_range = 1'b1;
            end
        end
        snap = in_range ? sel_word : '0;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        dout_d     = dout_q;
        err_pend_d = err_pend_q;
        err_d      = err_q;
        load       = 1'b0;
        shift_en   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = addr;
                    err_d   = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load       = 1'b1;
                word_d     = snap;
                err_pend_d = !in_range;
                cnt_d      = '0;
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (sout_ready) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        dout_d  = word_q;
                        err_d   = err_pend_q;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered from the next state.
        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_SHIFT);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            dout_q     <= '0;
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            dout_q     <= dout_d;
            err_pend_q <= err_pend_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    piso_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .din      (snap),
        .sout     (sout)
    );

    assign busy       = busy_q;
    assign sout_valid = valid_q;
    assign dout       = dout_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_register_reader.sv
// Scoreboard bench for register_reader: directed reads plus
// randomized reads with random back-pressure.
module tb_register_reader;

    localparam int W = 8;
    localparam int D = 6;
    localparam int A = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W*D-1:0] bank = '0;
    logic [A-1:0]   addr = '0;
    logic           start = 1'b0;
    logic           busy;
    logic           sout;
    logic           sout_valid;
    logic           sout_ready = 1'b1;
    logic [W-1:0]   dout;
    logic           done;
    logic           err;

    bit             exp_bits[$];
    logic [W:0]     exp_res[$];
    int             total = 0;
    int             bad = 0;
    bit             rnd_ready = 1'b0;

    always #5 clk = ~clk;

    register_reader #(
        .WIDTH (W),
        .DEPTH (D),
        .AW    (A)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bank       (bank),
        .addr       (addr),
        .start      (start),
        .busy       (busy),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_ready (sout_ready),
        .dout       (dout),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) sout_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Reference: a read returns the bank word as it stood at the request,
    // or zero with err for an address beyond the bank.
    task automatic expect_read(input int a);
        logic [W-1:0] w;
        w = (a < D) ? bank[a*W +: W] : '0;
        for (int i = 0; i < W; i++) exp_bits.push_back(w[i]);
        exp_res.push_back({(a >= D) ? 1'b1 : 1'b0, w});
    endtask

    task automatic run_read(input int a, input int exp_lat, input int st_from,
                            input int st_len, input bit chg, input bit pulses);
        int n;
        expect_read(a);
        addr  = A'(a);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 300) begin
            start = pulses && (n == 1 || n == 5);
            if (chg && n == 4) bank[5*W +: W] = 8'hFF;
            if (!rnd_ready) sout_ready = !(n >= st_from && n < st_from + st_len);
            tick();
            n++;
        end
        start = 1'b0;
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL read_timeout: got no done want done addr=%0d", a);
        end
        if (exp_lat >= 0) chk("done_latency", 32'(n), 32'(exp_lat));
        if (chg) bank[5*W +: W] = 8'hA6;
        start = pulses;
        tick();
        start = 1'b0;
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sout_valid && sout_ready) begin
                if (exp_bits.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_bit: got %0b want none", sout);
                end else begin
                    chk("sout_bit", 32'(sout), 32'(exp_bits.pop_front()));
                end
            end else if (sout_valid && exp_bits.size() != 0) begin
                chk("stall_hold", 32'(sout), 32'(exp_bits[0]));
            end
            if (done) begin
                if (exp_res.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_done: got done want none");
                end else begin
                    chk("err_dout", 32'({err, dout}), 32'(exp_res.pop_front()));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < D; i++) bank[i*W +: W] = W'($urandom);
        bank[5*W +: W] = 8'hA6;
        bank[2*W +: W] = 8'h81;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(sout_valid), 32'd0);
        chk("rst_outs", 32'({sout, done, err, dout}), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        run_read(5, 10, 0, 0, 1'b0, 1'b0);
        run_read(5, 13, 4, 3, 1'b0, 1'b0);
        run_read(5, 10, 0, 0, 1'b1, 1'b0);
        run_read(5, 10, 0, 0, 1'b0, 1'b1);
        run_read(7, 10, 0, 0, 1'b0, 1'b0);
        chk("err_held", 32'(err), 32'd1);
        run_read(2, 10, 0, 0, 1'b0, 1'b0);
        chk("err_cleared", 32'(err), 32'd0);

        // Abort a transfer after four bits have gone out.
        bank[1*W +: W] = 8'h5B;
        expect_read(1);
        addr  = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        sout_ready = 1'b1;
        repeat (5) tick();
        exp_bits.delete();
        exp_res.delete();
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(sout_valid), 32'd0);
        chk("abort_outs", 32'({sout, done, err, dout}), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("abort_no_done", 32'(done), 32'd0);
        bank[3*W +: W] = 8'h3C;
        run_read(3, 10, 0, 0, 1'b0, 1'b0);

        rnd_ready = 1'b1;
        repeat (40) begin
            int a;
            a = $urandom_range(0, 7);
            if (a < D) bank[a*W +: W] = W'($urandom);
            run_read(a, -1, 0, 0, 1'b0, 1'b0);
        end
        rnd_ready  = 1'b0;
        sout_ready = 1'b1;
        repeat (3) tick();
        chk("bits_drained", 32'(exp_bits.size()), 32'd0);
        chk("results_drained", 32'(exp_res.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_reader.md
# register_reader

Read-side companion to the 8-bit latch register bank. On request, the block selects one register of an eight-entry bank and snapshots its word. It then serialises the word LSB-first over a valid/ready bit stream, and also presents the word in parallel at completion. It sits between the register bank outputs and the serial debug/transfer path, so latch contents can be read without disturbing the writers.

## Interface
- `WIDTH`, default 8: bits per register.
- `DEPTH`, default 8: number of registers in the bank.
- `AW`, default 3: address width; DEPTH ≤ 2^AW.
- `clk  in  1`: single clock; all state updates on rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `bank  in  WIDTH*DEPTH`: flattened register outputs; register i occupies bits [i*WIDTH +: WIDTH].
- `addr  in  AW`: register index, sampled with `start`.
- `start  in  1`: read request, one cycle, honoured only in IDLE.
- `busy  out  1`: high from the cycle after an accepted `start` until DONE is left.
- `sout  out  1`: serial data bit.
- `sout_valid  out  1`: `sout` carries a valid bit.
- `sout_ready  in  1`: consumer accepts the bit when `sout_valid && sout_ready`.
- `dout  out  WIDTH`: parallel copy of the last word read; holds until the next read completes.
- `done  out  1`: one-cycle pulse when the last bit transfers.
- `err  out  1`: set with `done` when `addr` ≥ DEPTH; cleared on the next accepted `start`.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - `start=1` → latch `addr` → go to LOAD.
  - `start=0` → stay in IDLE.
- LOAD (1 cycle):
  - Snapshot `bank[addr]` into the shift register, or all-zero with the error bit pending if out of range.
  - Clear the bit counter; go to SHIFT.
  - Later changes on `bank` do not affect the snapshot.
- SHIFT:
  - `sout_valid=1`; `sout` = shift register bit 0.
  - On each handshake: shift right by one and increment the counter.
  - Handshake on bit WIDTH-1 → go to DONE.
  - `sout_ready=0` → hold `sout` and the counter unchanged; no timeout.
- DONE (1 cycle):
  - `done=1`; `dout` updated with the snapshot word; `err` reflects the range check.
  - Go to IDLE.
- `start` outside IDLE is ignored and not queued.
- Out-of-range read still shifts WIDTH zero bits, so the consumer framing stays intact.
- Counter width is clog2(WIDTH+1). No wrap is possible, because the FSM leaves SHIFT at count WIDTH-1.

## Timing
- Reset (asynchronous, immediate, any state):
  - FSM → IDLE.
  - `busy`, `sout`, `sout_valid`, `done`, `err` = 0; `dout` = 0; shift register and counter = 0.
- Reset mid-SHIFT aborts the transfer. No `done` is issued and no partial word reaches `dout`.
- Latency with `sout_ready` held high:
  - `start` at cycle 0 → LOAD at cycle 1 → first valid bit at cycle 2.
  - Last bit at cycle WIDTH+1; `done` at cycle WIDTH+2.
  - IDLE at cycle WIDTH+3, where a new `start` is accepted.
- Each stall cycle (`sout_valid && !sout_ready`) adds exactly one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `register_reader_pkg`:
  - State enum (IDLE, LOAD, SHIFT, DONE).
  - Default WIDTH/DEPTH/AW constants, shared with the register bank.
- Sub-module `piso_shifter`:
  - WIDTH-bit parallel-in serial-out shift register with load, shift-enable and asynchronous reset.
  - Instantiated once; the FSM and counter live in `register_reader`.

## Test plan
- Load bank register 5 = 0xA6, `start` with `addr`=5, `sout_ready`=1 → bits 0,1,1,0,0,1,0,1 on cycles 2–9; `done` at cycle 10; `dout`=0xA6; `err`=0.
- Same read with `sout_ready` deasserted for 3 cycles after bit 2 → `sout` holds bit 2 throughout the stall; `done` at cycle 13; `dout`=0xA6.
- Change `bank` register 5 from 0xA6 to 0xFF during SHIFT → serial stream and `dout` remain 0xA6.
- `start` pulses during SHIFT, DONE and LOAD → ignored; exactly one `done` per accepted request.
- DEPTH=6, `addr`=7 → 8 zero bits, `done` with `err`=1, `dout`=0x00; the next valid read clears `err`.
- Assert `rst` mid-SHIFT after bit 3 → all outputs 0 immediately, FSM in IDLE, no `done`; a subsequent read of 0x3C completes correctly.
